lpf_mem_port: RTL

- Responder end of the low-pass-filter memory port: serves the filter's lpf_flag/lpf_wr/lpf_x/lpf_y requests against the ZBT frame SRAM.
- Sits inside memory_interface behind the top-level SRAM time-slot arbiter; drives the SRAM only in cycles where the arbiter grants the slot.
- Packs two LOG_TRUNC pixels per LOG_MEM word (even x in the upper half) and returns read words with fixed latency so the filter can align by delay lines.

---
 rtl/lpf_mem_port.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/lpf_mem_port.sv
// lpf_mem_port: responder end of the low-pass filter's frame SRAM port.
// Accepts one filter request per granted slot, issues the ZBT address/write
// enable one cycle later and lines up write data (T+3) and read data (T+4)
// through a short valid-tagged pipeline.
module lpf_mem_port #(
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int LOG_WIDTH    = 10,
    parameter int LOG_HEIGHT   = 9,
    parameter int LOG_MEM      = 36,
    parameter int LOG_ADDR     = 19,
    parameter int BUFFER_WORDS = 153600,
    parameter int BASE_ADDR    = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  lpf_slot,
    input  logic                  buffer_sel,
    input  logic                  lpf_flag,
    input  logic                  lpf_wr,
    input  logic [LOG_WIDTH-1:0]  lpf_x,
    input  logic [LOG_HEIGHT-1:0] lpf_y,
    input  logic [LOG_MEM-1:0]    lpf_pixel_write,
    output logic                  done_lpf,
    output logic [LOG_MEM-1:0]    lpf_pixel_read,
    output logic                  lpf_read_valid,
    output logic [LOG_ADDR-1:0]   mem_addr,
    output logic                  mem_we,
    output logic [LOG_MEM-1:0]    mem_data_out,
    output logic                  mem_drive,
    input  logic [LOG_MEM-1:0]    mem_data_in
);

    typedef enum logic {IDLE, ACK} state_t;

    localparam logic [LOG_WIDTH:0]    X_LIMIT   = (LOG_WIDTH + 1)'(IMAGE_WIDTH);
    localparam logic [LOG_HEIGHT:0]   Y_LIMIT   = (LOG_HEIGHT + 1)'(IMAGE_HEIGHT);
    localparam logic [LOG_ADDR-1:0]   ROW_WORDS = LOG_ADDR'(IMAGE_WIDTH / 2);
    localparam logic [LOG_ADDR-1:0]   BUF_WORDS = LOG_ADDR'(BUFFER_WORDS);
    localparam logic [LOG_ADDR-1:0]   BASE      = LOG_ADDR'(BASE_ADDR);

    // Word address of a pixel pair: two pixels share a word, so x LSB drops out.
    function automatic logic [LOG_ADDR-1:0] pixel_addr(
        input logic                  sel,
        input logic [LOG_WIDTH-1:0]  x,
        input logic [LOG_HEIGHT-1:0] y
    );
        logic [LOG_ADDR-1:0] buf_ofs;
        buf_ofs = sel ? BUF_WORDS : '0;
        return BASE + buf_ofs + LOG_ADDR'(y) * ROW_WORDS + LOG_ADDR'(x[LOG_WIDTH-1:1]);
    endfunction

    state_t               state_q, state_d;
    logic                 accept;
    logic                 in_range;

    logic                 done_q, done_d;
    logic [LOG_ADDR-1:0]  mem_addr_q, mem_addr_d;
    logic                 mem_we_q, mem_we_d;

    logic                 vld_p1_q, vld_p1_d;
    logic                 wr_p1_q, wr_p1_d;
    logic                 ir_p1_q, ir_p1_d;
    logic [LOG_MEM-1:0]   wdata_p1_q, wdata_p1_d;

    logic                 vld_p2_q, vld_p2_d;
    logic                 wr_p2_q, wr_p2_d;
    logic                 ir_p2_q, ir_p2_d;
    logic [LOG_MEM-1:0]   wdata_p2_q, wdata_p2_d;

    logic                 rd_p3_q, rd_p3_d;
    logic                 ir_p3_q, ir_p3_d;
    logic                 drive_q, drive_d;
    logic [LOG_MEM-1:0]   data_out_q, data_out_d;

    logic                 read_valid_q, read_valid_d;
    logic [LOG_MEM-1:0]   pixel_read_q, pixel_read_d;

    // Accept a granted request in IDLE; ACK lasts one cycle so the still-high flag is not re-taken.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (lpf_flag && lpf_slot) begin
                    accept  = 1'b1;
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Address phase at T+1, data phase aligned to the ZBT two-cycle lag.
    always_comb begin
        in_range   = ({1'b0, lpf_x} < X_LIMIT) && ({1'b0, lpf_y} < Y_LIMIT);

        // Stage T -> T+1: address, write enable, acknowledge
        mem_addr_d = accept ? pixel_addr(buffer_sel, lpf_x, lpf_y) : mem_addr_q;
        mem_we_d   = accept && lpf_wr && in_range;
        done_d     = accept;
        vld_p1_d   = accept;
        wr_p1_d    = lpf_wr;
        ir_p1_d    = in_range;
        wdata_p1_d = lpf_pixel_write;

        // Stage T+1 -> T+2
        vld_p2_d   = vld_p1_q;
        wr_p2_d    = wr_p1_q;
        ir_p2_d    = ir_p1_q;
        wdata_p2_d = wdata_p1_q;

        // Stage T+2 -> T+3: write data onto the bus, read tag arrives with SRAM data
        drive_d    = vld_p2_q && wr_p2_q && ir_p2_q;
        data_out_d = drive_d ? wdata_p2_q : '0;
        rd_p3_d    = vld_p2_q && !wr_p2_q;
        ir_p3_d    = ir_p2_q;

        // Stage T+3 -> T+4: capture read word; out-of-range reads return zero
        read_valid_d = rd_p3_q;
        pixel_read_d = pixel_read_q;
        if (rd_p3_q) pixel_read_d = ir_p3_q ? mem_data_in : '0;
    end

    // Pipeline and output registers; reset drops every in-flight access.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done_q       <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            vld_p1_q     <= 1'b0;
            wr_p1_q      <= 1'b0;
            ir_p1_q      <= 1'b0;
            wdata_p1_q   <= '0;
            vld_p2_q     <= 1'b0;
            wr_p2_q      <= 1'b0;
            ir_p2_q      <= 1'b0;
            wdata_p2_q   <= '0;
            rd_p3_q      <= 1'b0;
            ir_p3_q      <= 1'b0;
            drive_q      <= 1'b0;
            data_out_q   <= '0;
            read_valid_q <= 1'b0;
            pixel_read_q <= '0;
        end else begin
            done_q       <= done_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            vld_p1_q     <= vld_p1_d;
            wr_p1_q      <= wr_p1_d;
            ir_p1_q      <= ir_p1_d;
            wdata_p1_q   <= wdata_p1_d;
            vld_p2_q     <= vld_p2_d;
            wr_p2_q      <= wr_p2_d;
            ir_p2_q      <= ir_p2_d;
            wdata_p2_q   <= wdata_p2_d;
            rd_p3_q      <= rd_p3_d;
            ir_p3_q      <= ir_p3_d;
            drive_q      <= drive_d;
            data_out_q   <= data_out_d;
            read_valid_q <= read_valid_d;
            pixel_read_q <= pixel_read_d;
        end
    end

    assign done_lpf       = done_q;
    assign mem_addr       = mem_addr_q;
    assign mem_we         = mem_we_q;
    assign mem_drive      = drive_q;
    assign mem_data_out   = data_out_q;
    assign lpf_read_valid = read_valid_q;
    assign lpf_pixel_read = pixel_read_q;

endmodule
